// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic-cycle responder backed by a word-addressed RAM.
// It applies WAIT_CYCLES wait states and supports byte-enabled writes.
// Each accepted request gets exactly one ack, rty or err pulse.
// Optional feature macro: WB_RAM_RANGE_ERR_EN.
//   Defined:   out-of-window addresses terminate with err.
//   Undefined: the word index wraps modulo DEPTH_WORDS, and err is never raised.
module wb_ram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_rty_o,
    output logic        wb_err_o,
    input  logic        hold_i
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [3:0]     wait_cnt;

    // Request captured at acceptance; WAIT ignores the live bus except cyc.
    logic [31:0]    adr_q;
    logic [31:0]    dat_q;
    logic           we_q;
    logic [3:0]     sel_q;
    logic           hold_q;

    // Effective request: live inputs in IDLE (zero-wait path), latched copy otherwise.
    logic [31:0]    req_adr;
    logic [31:0]    req_dat;
    logic           req_we;
    logic [3:0]     req_sel;
    logic           req_hold;

    logic [AW-1:0]  idx;
    logic           in_range;
    logic           ack_d;
    logic           rty_d;
    logic           err_d;
    logic           mem_we;
    logic           rd_en;

    logic [31:0]    mem [DEPTH_WORDS];

    // Select the request fields that the coming response will act on.
    always_comb begin
        if (state == S_IDLE) begin
            req_adr  = wb_adr_i;
            req_dat  = wb_dat_i;
            req_we   = wb_we_i;
            req_sel  = wb_sel_i;
            req_hold = hold_i;
        end else begin
            req_adr  = adr_q;
            req_dat  = dat_q;
            req_we   = we_q;
            req_sel  = sel_q;
            req_hold = hold_q;
        end
    end

    // Byte offset from the window base, converted to a word index; adr[1:0] drops out.
    assign idx = AW'((req_adr - ADDR_BASE) >> 2);

`ifdef WB_RAM_RANGE_ERR_EN
    // Addresses below the base wrap to huge offsets, so one compare covers both ends.
    assign in_range = ((req_adr - ADDR_BASE) >> 2) < 32'(DEPTH_WORDS);
`else
    assign in_range = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, count down or abort in WAIT, then one RESP cycle.
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // next_state unassigned and infers a latch.
        next_state = state;
        case (state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    next_state = S_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: choose the termination and RAM action for the edge entering RESP.
    always_comb begin
        ack_d  = 1'b0;
        rty_d  = 1'b0;
        err_d  = 1'b0;
        if (next_state == S_RESP) begin
            rty_d = req_hold;
            err_d = !req_hold && !in_range;
            ack_d = !req_hold && in_range;
        end
        mem_we = ack_d && req_we;
        rd_en  = ack_d && !req_we;
    end

    // Capture the request at acceptance and run the wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            hold_q   <= 1'b0;
        end else if (state == S_IDLE && wb_cyc_i && wb_stb_i) begin
            wait_cnt <= WAIT_LOAD;
            adr_q    <= wb_adr_i;
            dat_q    <= wb_dat_i;
            we_q     <= wb_we_i;
            sel_q    <= wb_sel_i;
            hold_q   <= hold_i;
        end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Byte-enabled RAM write; a reset edge drops any pending write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset so it can map onto RAM macros;
        // only the control path is reset.
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

    // Registered response strobes and read data; read data is zero unless a read is acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= ack_d;
            wb_rty_o <= rty_d;
            wb_err_o <= err_d;
            wb_dat_o <= rd_en ? mem[idx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed testbench for wb_ram_slave with default parameters (WAIT_CYCLES=1, DEPTH_WORDS=4096).
// Expected values are hand-computed; the out-of-range case follows WB_RAM_RANGE_ERR_EN.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;
    logic        rty;
    logic        err;
    logic        hold;

    int n_tests = 0;
    int n_fail  = 0;

    wb_ram_slave dut (
        .clk      (clk),
        .rst      (rst),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_dat_o (rdat),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_cyc_i (cyc),
        .wb_ack_o (ack),
        .wb_rty_o (rty),
        .wb_err_o (err),
        .hold_i   (hold)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Run one request; returns {err,rty,ack}, data at response, latency in cycles and extra pulses after it.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [3:0] s, input logic h,
                             output logic [31:0] resp, output logic [31:0] data,
                             output int lat, output int extra);
        adr  = a;
        wdat = d;
        we   = w;
        sel  = s;
        hold = h;
        cyc  = 1'b1;
        stb  = 1'b1;
        resp  = 32'h0;
        data  = 32'h0;
        lat   = 0;
        extra = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ack || rty || err) begin
                resp = {29'b0, err, rty, ack};
                data = rdat;
                lat  = i;
                break;
            end
        end
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (ack || rty || err) extra++;
        end
    endtask

    // Count response pulses over n idle cycles.
    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ack || rty || err) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] resp;
        logic [31:0] data;
        int          lat;
        int          extra;
        int          pulses;
        int          first;
        int          second;
        int          n_ack;

        rst  = 1'b1;
        adr  = 32'h0;
        wdat = 32'h0;
        we   = 1'b0;
        sel  = 4'h0;
        stb  = 1'b0;
        cyc  = 1'b0;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {29'b0, err, rty, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst = 1'b0;

        // Full-word write then read, ack two cycles after strobe.
        bus_cycle(32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, resp, data, lat, extra);
        check("wr_resp", resp, 32'h1);
        check("wr_lat", lat, 32'd2);
        check("wr_dat_zero", data, 32'h0);
        check("wr_single_pulse", extra, 32'd0);
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("rd_resp", resp, 32'h1);
        check("rd_lat", lat, 32'd2);
        check("rd_data", data, 32'hDEAD_BEEF);
        check("rd_single_pulse", extra, 32'd0);

        // Byte lanes 0 and 2 only.
        bus_cycle(32'h8000_0010, 32'h1122_3344, 1'b1, 4'b0101, 1'b0, resp, data, lat, extra);
        check("lane_wr_resp", resp, 32'h1);
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("lane_rd_data", data, 32'hDE22_BE44);

        // sel=0000 is acked and changes nothing.
        bus_cycle(32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 4'h0, 1'b0, resp, data, lat, extra);
        check("sel0_resp", resp, 32'h1);
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("sel0_rd_data", data, 32'hDE22_BE44);

        // hold at acceptance gives a single retry and no access.
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b1, resp, data, lat, extra);
        check("hold_rd_resp", resp, 32'h2);
        check("hold_rd_dat", data, 32'h0);
        check("hold_rd_lat", lat, 32'd2);
        check("hold_single_pulse", extra, 32'd0);
        bus_cycle(32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, resp, data, lat, extra);
        check("hold_wr_resp", resp, 32'h2);
        // Retry without hold; low address bits are ignored.
        bus_cycle(32'h8000_0013, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("retry_resp", resp, 32'h1);
        check("retry_data", data, 32'hDE22_BE44);

        // Abort: drop cyc while in WAIT.
        adr  = 32'h8000_0010;
        wdat = 32'hCAFE_F00D;
        we   = 1'b1;
        sel  = 4'hF;
        cyc  = 1'b1;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_early_resp", {29'b0, err, rty, ack}, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        count_pulses(4, pulses);
        check("abort_no_resp", pulses, 32'd0);
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("abort_rd_data", data, 32'hDE22_BE44);

        // Reset in the cycle before RESP of a write.
        adr  = 32'h8000_0010;
        wdat = 32'h5555_5555;
        we   = 1'b1;
        sel  = 4'hF;
        cyc  = 1'b1;
        stb  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_flags", {29'b0, err, rty, ack}, 32'h0);
        check("rstmid_dat", rdat, 32'h0);
        rst = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        count_pulses(4, pulses);
        check("rstmid_no_resp", pulses, 32'd0);
        bus_cycle(32'h8000_0010, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
        check("rstmid_rd_data", data, 32'hDE22_BE44);

        // Back-to-back: strobe held high gives acks every WAIT_CYCLES+2 = 3 cycles.
        adr   = 32'h8000_0010;
        we    = 1'b0;
        sel   = 4'hF;
        cyc   = 1'b1;
        stb   = 1'b1;
        first = 0;
        second = 0;
        n_ack = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                n_ack++;
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        count_pulses(3, pulses);
        check("b2b_first", first, 32'd2);
        check("b2b_spacing", second - first, 32'd3);
        check("b2b_count", n_ack, 32'd3);
        check("b2b_drain", pulses, 32'd0);

        // Out-of-range read one word past the window.
        bus_cycle(32'h8000_0000, 32'h0A0B_0C0D, 1'b1, 4'hF, 1'b0, resp, data, lat, extra);
        check("word0_wr_resp", resp, 32'h1);
        bus_cycle(32'h8000_4000, 32'h0, 1'b0, 4'hF, 1'b0, resp, data, lat, extra);
`ifdef WB_RAM_RANGE_ERR_EN
        check("oor_resp", resp, 32'h4);
        check("oor_dat", data, 32'h0);
`else
        check("oor_resp", resp, 32'h1);
        check("oor_dat", data, 32'h0A0B_0C0D);
`endif
        check("oor_single_pulse", extra, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone classic-cycle responder that serves the instruction-fetch path's ICache refill master, and optionally the data port, from an on-chip word-addressed RAM. It decodes a word index from the request address. It applies a programmable number of wait states and byte-enabled writes, then returns exactly one `wb_ack_o`, `wb_rty_o` or `wb_err_o` pulse per accepted request. It sits on the bus side of the instruction cache, at the opposite end of the master's refill handshake.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 4096: RAM depth in 32-bit words; must be a power of two, at least 2.
- `WAIT_CYCLES`, default 1: extra wait states inserted before the response; range 0..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wb_adr_i` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data; valid only while `wb_ack_o` is high.
- `wb_we_i` in 1: 1 means write.
- `wb_sel_i` in 4: byte enables; bit n enables byte lane `[8n+7:8n]`.
- `wb_stb_i` in 1: strobe.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_ack_o` out 1: normal termination, one-cycle pulse.
- `wb_rty_o` out 1: retry termination, one-cycle pulse.
- `wb_err_o` out 1: error termination, one-cycle pulse.
- `hold_i` in 1: RAM temporarily unavailable (for example, image reload); requests receive retry.

## Operation
- FSM states:
  - IDLE to WAIT when `wb_cyc_i & wb_stb_i` and `WAIT_CYCLES>0`. Latch adr, dat, we, sel and `hold_i`. Load the wait counter with `WAIT_CYCLES-1`.
  - IDLE to RESP when the same request arrives and `WAIT_CYCLES==0`.
  - WAIT decrements the counter each cycle; at 0 it moves to RESP.
  - RESP always returns to IDLE after one cycle.
- Abort: `wb_cyc_i` low in WAIT returns the FSM to IDLE. No write, no response.
- Word index is `(adr - ADDR_BASE) >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits. `adr[1:0]` is ignored.
- Exactly one of ack, rty or err is asserted per request, always in RESP:
  - rty if the latched `hold_i` is 1; no access is performed.
  - else err if the address is out of range (see Configuration).
  - else ack.
- Write:
  - Performed on the clock edge entering RESP, only when the outcome is ack.
  - Only bytes with `sel=1` are updated; `sel=0000` is acked and changes nothing.
- Read: RAM word registered on the edge entering RESP. `wb_dat_o` is zero whenever ack is low, and on rty or err.
- `wb_dat_o` is 0 on write acks.
- RAM contents are not reset. There is no initialisation beyond simulation `$readmemh` hook-up, which is outside this block.

## Timing
- All outputs are registered. Reset values: `wb_ack_o`, `wb_rty_o` and `wb_err_o` are 0; `wb_dat_o` is 32'h0; FSM is in IDLE; counter is 0.
- Latency: with the request first sampled at edge N, the response is high during cycle N+1+`WAIT_CYCLES`, for exactly one cycle.
- Back-to-back: a request still or newly asserted in the cycle after RESP is treated as new. Minimum spacing between responses is `WAIT_CYCLES+2` cycles.
- Request inputs are sampled only in IDLE; changes during WAIT are ignored, except the `wb_cyc_i` abort.
- `rst` high at any edge forces IDLE and clears all outputs the next cycle. A pending write is dropped.
- `hold_i` is sampled only at acceptance.

## Configuration
- `WB_RAM_RANGE_ERR_EN` defined:
  - An address outside `[ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS)` produces `wb_err_o` in RESP.
  - No RAM read or write occurs, and `wb_dat_o` is 0.
  - rty takes priority over err.
- Not defined:
  - No range check and `wb_err_o` is tied to 0.
  - The index wraps modulo `DEPTH_WORDS`; for example, `ADDR_BASE+4*DEPTH_WORDS` aliases word 0.

## Test plan
- WAIT_CYCLES=1: write 32'hDEADBEEF with sel=1111 to 32'h8000_0010, then read the same address. Each access is acked exactly 2 cycles after stb. Read data is 32'hDEADBEEF.
- Byte lanes: write 32'h11223344 with sel=0101 over the stored 32'hDEADBEEF. Readback is 32'hDE22BE44.
- `hold_i`=1 at acceptance: `wb_rty_o` pulses once, no ack, and memory is unchanged. A retry with `hold_i`=0 acks.
- Abort: drop `wb_cyc_i` during WAIT on a write of 32'hCAFEF00D. No response, and a later read returns the old value.
- Out-of-range read of 32'h8000_4000 with DEPTH_WORDS=4096:
  - With `WB_RAM_RANGE_ERR_EN`, `wb_err_o` pulses and `wb_dat_o`=0.
  - Without it, the read is acked with the contents of word 0.
- Assert `rst` in the cycle before RESP of a write. No ack follows, all outputs are 0 the next cycle, and the target word is unchanged.
